id_ex_elastic_reg: RTL and testbench

//  Parametrised ID->EX pipeline register with valid/ready handshake and 2-entry skid buffer.

---
 rtl/id_ex_pkg.sv | 34 +++
 rtl/id_ex_slot.sv | 24 ++
 rtl/id_ex_elastic_reg.sv | 146 ++++++++++++++
 tb/tb_id_ex_elastic_reg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared widths, payload layout and occupancy encodings for the ID->EX elastic register.
package id_ex_pkg;

  localparam int unsigned INSTR_W_DEF = 8;
  localparam int unsigned ALUOP_W_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned RADDR_W_DEF = 3;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ALUOP_W_DEF-1:0] aluop;
    logic                   regwrite;
    logic                   loadimm;
    logic [DATA_W_DEF-1:0]  rdata1;
    logic [RADDR_W_DEF-1:0] wreg;
    logic [DATA_W_DEF-1:0]  imm;
  } id_ex_payload_t;

  localparam int unsigned PAYLOAD_W_DEF = $bits(id_ex_payload_t);

  // Occupancy is {main_v, skid_v}; 2'b01 never occurs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  function automatic int unsigned payload_width(int unsigned instr_w, int unsigned aluop_w,
                                                int unsigned data_w, int unsigned raddr_w);
    return instr_w + aluop_w + 2 + 2 * data_w + raddr_w;
  endfunction

endpackage

// File: rtl/id_ex_slot.sv
// One payload+valid register, loaded when en is high; payload only captured for valid entries.
module id_ex_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         v_d,
  input  logic [W-1:0] d,
  output logic         v,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      q <= '0;
    end else if (en) begin
      v <= v_d;
      if (v_d) q <= d;
    end
  end

endmodule

// File: rtl/id_ex_elastic_reg.sv
// ID->EX pipeline register with valid/ready handshake and a skid slot so id_ready is registered.
// Optional saturating stall/bubble counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_elastic_reg
  import id_ex_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RADDR_W = RADDR_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               id_regwrite,
  input  logic               id_loadimm,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [RADDR_W-1:0] id_wreg,
  input  logic [DATA_W-1:0]  id_imm,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [INSTR_W-1:0] ex_instr,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_regwrite,
  output logic               ex_loadimm,
  output logic [DATA_W-1:0]  ex_rdata1,
  output logic [RADDR_W-1:0] ex_wreg,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int unsigned PL_W = payload_width(INSTR_W, ALUOP_W, DATA_W, RADDR_W);

  logic [PL_W-1:0] in_pl, main_q, skid_q, main_d, skid_d;
  logic            main_v, skid_v, main_en, skid_en, main_vd, skid_vd;
  logic            main_regwrite;
  logic            in_fire, out_fire;
  state_e          state;

  assign in_pl = {id_instr, id_aluop, id_regwrite, id_loadimm, id_rdata1, id_wreg, id_imm};

  assign state    = state_e'({main_v, skid_v});
  assign id_ready = !skid_v;
  assign in_fire  = id_valid & id_ready;
  assign out_fire = main_v & ex_ready;

  // Next-occupancy and slot load control.
  always_comb begin
    main_en = 1'b0;
    main_vd = main_v;
    main_d  = in_pl;
    skid_en = 1'b0;
    skid_vd = skid_v;
    skid_d  = in_pl;
    if (flush) begin
      main_en = 1'b1;
      main_vd = 1'b0;
      skid_en = 1'b1;
      skid_vd = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_en = 1'b1;
            main_vd = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
            main_vd = 1'b1;
          end else if (in_fire) begin
            skid_en = 1'b1;
            skid_vd = 1'b1;
          end else if (out_fire) begin
            main_en = 1'b1;
            main_vd = 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_en = 1'b1;
            main_vd = 1'b1;
            main_d  = skid_q;
            skid_en = 1'b1;
            skid_vd = 1'b0;
          end
        end
        default: begin
          main_en = 1'b1;
          main_vd = 1'b0;
          skid_en = 1'b1;
          skid_vd = 1'b0;
        end
      endcase
    end
  end

  id_ex_slot #(.W(PL_W)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .v_d (main_vd),
    .d   (main_d),
    .v   (main_v),
    .q   (main_q)
  );

  id_ex_slot #(.W(PL_W)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .v_d (skid_vd),
    .d   (skid_d),
    .v   (skid_v),
    .q   (skid_q)
  );

  assign {ex_instr, ex_aluop, main_regwrite, ex_loadimm, ex_rdata1, ex_wreg, ex_imm} = main_q;
  assign ex_valid    = main_v;
  // Bubbles must never write back, even if the stale payload had regwrite set.
  assign ex_regwrite = main_regwrite & main_v;

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_v && !ex_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!main_v && ex_ready && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Directed self-checking bench for id_ex_elastic_reg (CNT_W=4).
module tb_id_ex_elastic_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       id_valid;
  logic       id_ready;
  logic [7:0] id_instr;
  logic [3:0] id_aluop;
  logic       id_regwrite;
  logic       id_loadimm;
  logic [7:0] id_rdata1;
  logic [2:0] id_wreg;
  logic [7:0] id_imm;
  logic       ex_valid;
  logic       ex_ready;
  logic [7:0] ex_instr;
  logic [3:0] ex_aluop;
  logic       ex_regwrite;
  logic       ex_loadimm;
  logic [7:0] ex_rdata1;
  logic [2:0] ex_wreg;
  logic [7:0] ex_imm;
  logic [3:0] stall_cnt;
  logic [3:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_elastic_reg #(
    .INSTR_W(8), .ALUOP_W(4), .DATA_W(8), .RADDR_W(3), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_aluop(id_aluop), .id_regwrite(id_regwrite),
    .id_loadimm(id_loadimm), .id_rdata1(id_rdata1), .id_wreg(id_wreg), .id_imm(id_imm),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .ex_aluop(ex_aluop), .ex_regwrite(ex_regwrite),
    .ex_loadimm(ex_loadimm), .ex_rdata1(ex_rdata1), .ex_wreg(ex_wreg), .ex_imm(ex_imm),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] instr, input logic rw);
    id_valid    = 1'b1;
    id_instr    = instr;
    id_aluop    = instr[3:0];
    id_regwrite = rw;
    id_loadimm  = instr[0];
    id_rdata1   = ~instr;
    id_wreg     = instr[2:0];
    id_imm      = instr + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    ex_ready = 1'b0;
    push(8'h5A, 1'b1);
    step();
    total++;
    if (ex_valid !== 1'b1) begin bad++; $display("FAIL reset_pre_valid got=%b exp=1", ex_valid); end
    // Async reset mid-stream, no clock edge needed.
    #2 rst = 1'b0;
    #1;
    total++;
    if ({ex_valid, ex_regwrite, id_ready} !== 3'b001) begin
      bad++; $display("FAIL reset_async v/rw/rdy got=%b exp=001", {ex_valid, ex_regwrite, id_ready});
    end
    total++;
    if ({stall_cnt, bubble_cnt} !== 8'h00) begin
      bad++; $display("FAIL reset_cnt got=%h exp=00", {stall_cnt, bubble_cnt});
    end
    id_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    total++;
    if ({ex_valid, id_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_exit v/rdy got=%b exp=01", {ex_valid, id_ready});
    end
  endtask

  task automatic test_streaming();
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(seq[i], 1'b0);
      step();
      total++;
      if ({ex_valid, id_ready, ex_instr} !== {2'b11, seq[i]}) begin
        bad++; $display("FAIL stream_%0d v/rdy/instr got=%b/%b/%h exp=1/1/%h", i, ex_valid, id_ready, ex_instr, seq[i]);
      end
    end
    total++;
    if ({ex_imm, ex_rdata1, ex_wreg} !== {8'h34, 8'hCC, 3'd3}) begin
      bad++; $display("FAIL stream_payload got=%h/%h/%h exp=34/cc/3", ex_imm, ex_rdata1, ex_wreg);
    end
    id_valid = 1'b0;
    step();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", ex_valid); end
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    push(8'hA1, 1'b0);
    step();
    total++;
    if ({ex_valid, id_ready, ex_instr} !== {2'b11, 8'hA1}) begin
      bad++; $display("FAIL bp_one got=%b/%b/%h exp=1/1/a1", ex_valid, id_ready, ex_instr);
    end
    push(8'hA2, 1'b0);
    step();
    total++;
    if ({ex_valid, id_ready, ex_instr} !== {2'b10, 8'hA1}) begin
      bad++; $display("FAIL bp_full got=%b/%b/%h exp=1/0/a1", ex_valid, id_ready, ex_instr);
    end
    push(8'hEE, 1'b0);
    step();
    total++;
    if ({ex_valid, id_ready, ex_instr} !== {2'b10, 8'hA1}) begin
      bad++; $display("FAIL bp_hold got=%b/%b/%h exp=1/0/a1", ex_valid, id_ready, ex_instr);
    end
    id_valid = 1'b0;
    ex_ready = 1'b1;
    step();
    total++;
    if ({ex_valid, id_ready, ex_instr} !== {2'b11, 8'hA2}) begin
      bad++; $display("FAIL bp_rel1 got=%b/%b/%h exp=1/1/a2", ex_valid, id_ready, ex_instr);
    end
    step();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL bp_rel2 got=%b exp=0", ex_valid); end
  endtask

  task automatic test_flush_full();
    ex_ready = 1'b0;
    push(8'hC1, 1'b1);
    step();
    push(8'hC2, 1'b1);
    step();
    total++;
    if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_prefull rdy got=%b exp=0", id_ready); end
    push(8'hB3, 1'b1);
    flush    = 1'b1;
    ex_ready = 1'b1;
    step();
    total++;
    if ({ex_valid, id_ready, ex_regwrite} !== 3'b010) begin
      bad++; $display("FAIL flush_full v/rdy/rw got=%b exp=010", {ex_valid, id_ready, ex_regwrite});
    end
    flush    = 1'b0;
    id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (ex_valid !== 1'b0) begin
        bad++; $display("FAIL flush_ghost_%0d v got=%b instr=%h exp=0", i, ex_valid, ex_instr);
      end
    end
  endtask

  task automatic test_bubble_gating();
    ex_ready = 1'b0;
    push(8'hD1, 1'b1);
    step();
    total++;
    if ({ex_valid, ex_regwrite} !== 2'b11) begin
      bad++; $display("FAIL gate_pre got=%b exp=11", {ex_valid, ex_regwrite});
    end
    id_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if ({ex_valid, ex_regwrite} !== 2'b00) begin
      bad++; $display("FAIL gate_post got=%b exp=00", {ex_valid, ex_regwrite});
    end
  endtask

  task automatic test_perf_cnt();
    logic [3:0] exp_stall;
    logic [3:0] exp_bubble;
`ifdef ID_EX_PERF_CNT_EN
    exp_stall  = 4'd15;
    exp_bubble = 4'd3;
`else
    exp_stall  = 4'd0;
    exp_bubble = 4'd0;
`endif
    ex_ready = 1'b0;
    id_valid = 1'b0;
    do_reset();
    total++;
    if ({stall_cnt, bubble_cnt} !== 8'h00) begin
      bad++; $display("FAIL perf_start got=%h exp=00", {stall_cnt, bubble_cnt});
    end
    push(8'hE1, 1'b0);
    step();
    id_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    total++;
    if (stall_cnt !== exp_stall) begin
      bad++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (bubble_cnt !== exp_bubble) begin
      bad++; $display("FAIL perf_bubble got=%0d exp=%0d", bubble_cnt, exp_bubble);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (stall_cnt !== exp_stall) begin
      bad++; $display("FAIL perf_flush_keep got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  initial begin
    rst         = 1'b0;
    flush       = 1'b0;
    id_valid    = 1'b0;
    id_instr    = '0;
    id_aluop    = '0;
    id_regwrite = 1'b0;
    id_loadimm  = 1'b0;
    id_rdata1   = '0;
    id_wreg     = '0;
    id_imm      = '0;
    ex_ready    = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_bubble_gating();
    test_perf_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
